// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM.
// Build macro MULTICYCLE_ADDI_EN adds the ADDIEX/ADDIWB states.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Encodings 9/10 stay unused (illegal) when the addi states are not built.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
`ifdef MULTICYCLE_ADDI_EN
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`endif
    S_JEX     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_word_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle. The datapath side is master
// (supplies opcode and zero flag), the controller is slave.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic [3:0] state;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       iord;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;

  modport master (
    output op, zero,
    input  state, pcen, memwrite, irwrite, regwrite, regdst, memtoreg,
           iord, alusrca, alusrcb, pcsrc, aluop
  );

  modport slave (
    input  op, zero,
    output state, pcen, memwrite, irwrite, regwrite, regdst, memtoreg,
           iord, alusrca, alusrcb, pcsrc, aluop
  );
endinterface

// File: rtl/mips_multicycle_outdec.sv
// Moore decode: registered state -> datapath control word (pure combinational).
// Honours MULTICYCLE_ADDI_EN for the ADDIEX/ADDIWB entries.
module mips_multicycle_outdec
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  output ctrl_word_t o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.alusrcb = SRCB_FOUR;
        o_ctrl.aluop   = ALUOP_ADD;
        o_ctrl.pcsrc   = PCSRC_ALU;
        o_ctrl.irwrite = 1'b1;
        o_ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        o_ctrl.alusrcb = SRCB_IMMSH;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD:  o_ctrl.iord = 1'b1;
      S_MEMWB: begin
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_B;
        o_ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      S_BEQEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_B;
        o_ctrl.aluop   = ALUOP_SUB;
        o_ctrl.pcsrc   = PCSRC_ALUOUT;
        o_ctrl.branch  = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = SRCB_IMM;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: o_ctrl.regwrite = 1'b1;
`else
      4'd9, 4'd10: o_ctrl = '0;
`endif
      S_JEX: begin
        o_ctrl.pcsrc   = PCSRC_JUMP;
        o_ctrl.pcwrite = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: state register, next-state logic and pcen.
// Build macro MULTICYCLE_ADDI_EN enables native addi sequencing.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.slave bus
);

  state_t     r_state;
  ctrl_word_t w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_RTYPEEX;
            OP_BEQ:       r_state <= S_BEQEX;
`ifdef MULTICYCLE_ADDI_EN
            OP_ADDI:      r_state <= S_ADDIEX;
`else
            OP_ADDI:      r_state <= S_FETCH;
`endif
            OP_J:         r_state <= S_JEX;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:  r_state <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   r_state <= S_MEMWB;
        S_RTYPEEX: r_state <= S_RTYPEWB;
`ifdef MULTICYCLE_ADDI_EN
        S_ADDIEX:  r_state <= S_ADDIWB;
`endif
        // Final states and illegal encodings all return to fetch.
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  mips_multicycle_outdec u_outdec (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  assign bus.state    = r_state;
  assign bus.pcen     = w_ctrl.pcwrite | (w_ctrl.branch & bus.zero);
  assign bus.memwrite = w_ctrl.memwrite;
  assign bus.irwrite  = w_ctrl.irwrite;
  assign bus.regwrite = w_ctrl.regwrite;
  assign bus.regdst   = w_ctrl.regdst;
  assign bus.memtoreg = w_ctrl.memtoreg;
  assign bus.iord     = w_ctrl.iord;
  assign bus.alusrca  = w_ctrl.alusrca;
  assign bus.alusrcb  = w_ctrl.alusrcb;
  assign bus.pcsrc    = w_ctrl.pcsrc;
  assign bus.aluop    = w_ctrl.aluop;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-path model plus directed literal checks.
// Honours MULTICYCLE_ADDI_EN for the addi expectations.
module tb_mips_multicycle_ctrl;

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {pcen, memwrite, irwrite, regwrite, regdst, memtoreg, iord, alusrca, alusrcb, pcsrc, aluop}
  logic [13:0] dut_word;
  assign dut_word = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.regdst,
                     bus.memtoreg, bus.iord, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected control word straight from the per-state rules of the controller.
  function automatic logic [13:0] exp_word(input int s, input logic z);
    logic pcw, br, mw, irw, rw, rd, mtr, iod, asa;
    logic [1:0] srcb, psrc, aop;
    {pcw, br, mw, irw, rw, rd, mtr, iod, asa} = '0;
    srcb = 2'b00; psrc = 2'b00; aop = 2'b00;
    case (s)
      0:  begin srcb = 2'b01; irw = 1; pcw = 1; end
      1:  srcb = 2'b11;
      2:  begin asa = 1; srcb = 2'b10; end
      3:  iod = 1;
      4:  begin mtr = 1; rw = 1; end
      5:  begin iod = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; br = 1; end
      9:  begin asa = 1; srcb = 2'b10; end
      10: rw = 1;
      11: begin psrc = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw | (br & z), mw, irw, rw, rd, mtr, iod, asa, srcb, psrc, aop};
  endfunction

  // Model: after DECODE, the whole remaining state path is chosen from the opcode.
  int m_state = 0;
  bit m_valid = 0;
  int m_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_state = 0;
      m_q.delete();
      m_valid = 1;
    end else if (m_valid) begin
      if (m_state == 0) begin
        m_state = 1;
      end else begin
        if (m_state == 1) begin
          m_q.delete();
          case (bus.op)
            6'b100011: m_q = '{2, 3, 4};
            6'b101011: m_q = '{2, 5};
            6'b000000: m_q = '{6, 7};
            6'b000100: m_q = '{8};
            6'b000010: m_q = '{11};
`ifdef MULTICYCLE_ADDI_EN
            6'b001000: m_q = '{9, 10};
`endif
            default: ;
          endcase
        end
        m_state = (m_q.size() > 0) ? m_q.pop_front() : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_state", {28'd0, bus.state}, m_state);
      check("model_ctrl", {18'd0, dut_word}, {18'd0, exp_word(m_state, bus.zero)});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // seq holds expected states, first in the lowest nibble; cw is checked when state == cs.
  task automatic run_instr(input string name, input logic [5:0] o, input logic z,
                           input logic [31:0] seq, input int n,
                           input logic [3:0] cs, input logic [13:0] cw);
    bus.op   = o;
    bus.zero = z;
    for (int i = 0; i < n; i++) begin
      check({name, "_state"}, {28'd0, bus.state}, {28'd0, seq[4*i +: 4]});
      if (seq[4*i +: 4] == cs)
        check({name, "_ctrl"}, {18'd0, dut_word}, {18'd0, cw});
      if (i < n - 1) step();
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.op   = 6'b000000;
    bus.zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;

    check("reset_state", {28'd0, bus.state}, 32'd0);
    check("reset_ctrl", {18'd0, dut_word}, {18'd0, 14'b10100000010000});

    run_instr("lw",   6'b100011, 1'b0, 32'h043210, 6, 4'd4,  14'b00010100000000);
    run_instr("sw",   6'b101011, 1'b0, 32'h05210,  5, 4'd5,  14'b01000010000000);
    run_instr("beq1", 6'b000100, 1'b1, 32'h0810,   4, 4'd8,  14'b10000001000101);
    run_instr("beq0", 6'b000100, 1'b0, 32'h0810,   4, 4'd8,  14'b00000001000101);
    run_instr("rtex", 6'b000000, 1'b0, 32'h07610,  5, 4'd6,  14'b00000001000010);
    run_instr("rtwb", 6'b000000, 1'b1, 32'h07610,  5, 4'd7,  14'b00011000000000);
    run_instr("j",    6'b000010, 1'b0, 32'h0B10,   4, 4'd11, 14'b10000000001000);
`ifdef MULTICYCLE_ADDI_EN
    run_instr("addi", 6'b001000, 1'b0, 32'h0A910,  5, 4'd10, 14'b00010000000000);
`else
    run_instr("addi", 6'b001000, 1'b0, 32'h010,    3, 4'd1,  14'b00000000110000);
`endif
    run_instr("unk",  6'b111111, 1'b1, 32'h010,    3, 4'd1,  14'b00000000110000);

    // Abandon a store in MEMWR with reset.
    bus.op = 6'b101011;
    step(); step(); step();
    check("rst_mid_state5", {28'd0, bus.state}, 32'd5);
    reset = 1'b1;
    step();
    check("rst_mid_state", {28'd0, bus.state}, 32'd0);
    check("rst_mid_memwrite", {31'd0, bus.memwrite}, 32'd0);
    check("rst_mid_regwrite", {31'd0, bus.regwrite}, 32'd0);
    reset = 1'b0;
    run_instr("post_rst", 6'b000010, 1'b0, 32'h0B10, 4, 4'd11, 14'b10000000001000);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
